// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the 32x32 register file write port,
// with a per-register busy scoreboard and RAW-hazard flags for decode.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  rs1_hazard,
    output logic                  rs2_hazard,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [5*N_REQ-1:0]    req_rd,
    input  logic [32*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rf_reg_write,
    output logic [4:0]            rf_write_reg,
    output logic [31:0]           rf_write_data,
    output logic [31:0]           busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0] grant;
    logic [PW-1:0]    g_idx;
    logic             xfer;
    logic [4:0]       sel_rd;
    logic [31:0]      sel_data;

    logic             rf_reg_write_q, rf_reg_write_d;
    logic [4:0]       rf_write_reg_q, rf_write_reg_d;
    logic [31:0]      rf_write_data_q, rf_write_data_d;
    logic [31:0]      busy_q, busy_d;

    // The in-flight write still counts as pending until the register file has stored it.
    function automatic logic raw_hazard(input logic [4:0]  rs,
                                        input logic [31:0] b,
                                        input logic        wr,
                                        input logic [4:0]  wreg);
        return (rs != 5'd0) && (b[rs] || (wr && (wreg == rs)));
    endfunction

    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        g_idx = '0;
        xfer  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!xfer && req_valid[idx]) begin
                xfer       = 1'b1;
                grant[idx] = 1'b1;
                g_idx      = PW'(idx);
            end
        end
        if (rst) begin
            grant = '0;
            xfer  = 1'b0;
        end
    end

    assign sel_rd   = req_rd[5*int'(g_idx) +: 5];
    assign sel_data = req_data[32*int'(g_idx) +: 32];

    always_comb begin
        rr_ptr_d        = rr_ptr_q;
        rf_reg_write_d  = 1'b0;
        rf_write_reg_d  = rf_write_reg_q;
        rf_write_data_d = rf_write_data_q;
        busy_d          = busy_q;
        if (xfer) begin
            rr_ptr_d        = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);
            rf_reg_write_d  = (sel_rd != 5'd0);
            rf_write_reg_d  = sel_rd;
            rf_write_data_d = sel_data;
            busy_d[sel_rd]  = 1'b0;
        end
        // Issue is applied after the clear so a same-cycle set/clear leaves the new producer pending.
        if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q        <= '0;
            rf_reg_write_q  <= 1'b0;
            rf_write_reg_q  <= 5'd0;
            rf_write_data_q <= 32'd0;
            busy_q          <= 32'd0;
        end else begin
            rr_ptr_q        <= rr_ptr_d;
            rf_reg_write_q  <= rf_reg_write_d;
            rf_write_reg_q  <= rf_write_reg_d;
            rf_write_data_q <= rf_write_data_d;
            busy_q          <= busy_d;
        end
    end

    assign req_ready     = grant;
    assign rf_reg_write  = rf_reg_write_q;
    assign rf_write_reg  = rf_write_reg_q;
    assign rf_write_data = rf_write_data_q;
    assign busy          = busy_q;
    assign rs1_hazard    = !rst && raw_hazard(rs1, busy_q, rf_reg_write_q, rf_write_reg_q);
    assign rs2_hazard    = !rst && raw_hazard(rs2, busy_q, rf_reg_write_q, rf_write_reg_q);

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32x32 register file (x0 hard-wired to zero) among `N_REQ` writeback sources, such as the ALU, load unit and multiplier. Round-robin arbitration with a valid/ready handshake picks one source per cycle. The block also keeps a per-register busy scoreboard: issue sets a bit, writeback clears it. The decode stage uses this to detect RAW hazards. It drives the register file's `reg_write` / `write_reg` / `write_data` from a registered stage.

## Interface
- `N_REQ`, default 3, is the number of writeback requesters (2..8).
- `clk`  in  1  is the single clock; everything is rising-edge.
- `rst`  in  1  is the synchronous, active-high reset.
- `issue_valid`  in  1  means the decode stage issued an instruction that will write `issue_rd`.
- `issue_rd`  in  5  is the destination register of the issued instruction.
- `rs1`, `rs2`  in  5 each  are the source registers queried by decode.
- `rs1_hazard`, `rs2_hazard`  out  1 each  are combinational RAW-hazard flags.
- `req_valid`  in  N_REQ  carries one writeback request per source.
- `req_rd`  in  5*N_REQ  is the destination per source; source i occupies bits [5i+4:5i].
- `req_data`  in  32*N_REQ  is the data per source; source i occupies bits [32i+31:32i].
- `req_ready`  out  N_REQ  is the combinational one-hot grant.
- `rf_reg_write`  out  1  is the write enable to the register file.
- `rf_write_reg`  out  5  is the write address to the register file.
- `rf_write_data`  out  32  is the write data to the register file.
- `busy`  out  32  is the scoreboard; bit 0 is always 0.

## Operation
- **Arbitration**
  - `rr_ptr` is a pointer in 0..N_REQ-1.
  - The grant goes to the first i with `req_valid[i]=1`, searching from `rr_ptr` upward with wrap-around.
  - `req_ready` is one-hot on that i, or all zero when no source is valid. It never depends on `req_ready` feedback.
  - A transfer on source g occurs when `req_valid[g] & req_ready[g]`.
  - On a transfer, `rr_ptr` becomes (g+1) mod N_REQ.
  - With no transfer, `rr_ptr` holds.
  - A source holds `req_valid`, `req_rd` and `req_data` stable until it is granted.
- **Write stage**
  - On a transfer, the next edge registers `rf_write_reg = req_rd[g]` and `rf_write_data = req_data[g]`.
  - At the same edge, `rf_reg_write` becomes 1, unless `req_rd[g]==0`.
  - A transfer with rd=0 is accepted and consumed, but `rf_reg_write` stays 0.
  - With no transfer, the next edge sets `rf_reg_write = 0`. Address and data hold their last values.
- **Scoreboard**
  - A transfer with rd≠0 clears `busy[rd]`.
  - `issue_valid` with `issue_rd≠0` sets `busy[issue_rd]`.
  - An issue to an already busy rd leaves it busy. There is no count of outstanding writes; decode stalls on the hazard flag.
  - Set and clear of the same rd in the same cycle: **set wins**. The new producer is pending.
  - Issue to x0 is ignored.
- **Hazard flags**
  - `rsN_hazard = (rsN≠0) & (busy[rsN] | (rf_reg_write & rf_write_reg==rsN))`.
  - This covers the cycle where the write has left the scoreboard but is not yet stored in the register file.
  - rsN=0 never flags.

## Timing
- **Reset** (synchronous, on `rst`=1 at an edge):
  - `busy` = 0 and `rr_ptr` = 0.
  - `rf_reg_write` = 0, `rf_write_reg` = 0, `rf_write_data` = 0.
  - While `rst`=1, `req_ready` = 0 and the hazard flags are 0.
- **Reset mid-operation:** a registered write that is in flight is dropped (`rf_reg_write` forced to 0). Pending scoreboard entries are lost.
- **Latency from transfer to register file update:**
  - At edge k the transfer is accepted and the `rf_*` outputs are registered.
  - At edge k+1 the register file stores the data.
  - Decode reading at cycle k+2 or later sees the new value.
- **Hazard timing:** the hazard flag for that rd stays 1 through the cycle after edge k and drops once `rf_reg_write` deasserts or moves to a different register.
- **Throughput:** one writeback per cycle, sustained. With all N sources continuously valid, each source is granted exactly once every N cycles.
- **Combinational paths:** the only combinational paths are `req_valid` → `req_ready` and `rs*` / `busy` / `rf_*` → `rsN_hazard`.

## Test plan
- **Single writeback.** Reset, then issue rd=5. Next cycle `busy[5]=1`, and rs1=5 gives `rs1_hazard=1`. Source 1 then writes rd=5, data=0xDEADBEEF. Required:
  - `req_ready=3'b010`.
  - Next cycle `rf_reg_write=1`, `rf_write_reg=5`, `rf_write_data=0xDEADBEEF`, `busy[5]=0`, `rs1_hazard` still 1.
  - One cycle later `rs1_hazard=0`.
- **Round-robin fairness.** All 3 sources hold valid for 6 cycles, starting from `rr_ptr=0`. Required grant order: 0, 1, 2, 0, 1, 2.
- **Pointer wrap.** Only source 2 is valid, then only sources 0 and 2 are valid. Required grants: 2, then 0.
- **Writes to x0.** Source 0 writes rd=0 with data 0x1234. Required: `req_ready[0]=1`, the next cycle has `rf_reg_write=0`, and `busy[0]` stays 0.
- **Set/clear collision.** Issue rd=7 while source 2 completes rd=7 in the same cycle. Required:
  - Next cycle `busy[7]=1`.
  - `rf_reg_write=1` with `rf_write_reg=7`.
- **Reset mid-operation.** A write is registered (`rf_reg_write=1`) and `busy=0x0000_0110`, then `rst` is pulsed for one cycle. Required: `rf_reg_write=0`, `busy=0`, `rr_ptr=0`, `rf_write_reg=0`, `rf_write_data=0`.
